sort8_frame_sched: RTL and testbench
====================================

Name: sort8_frame_sched

Overview:
- Sequencer wrapped around the combinational 8-input bitonic sort network (BitonicSortX8) in the Huffman sortnet.
- Accepts a frame of 1..8 entries over a valid/ready stream and pads unused lanes.
- Fires the sorter once, registers the result, then drains exactly the received entries in ascending key order over a valid/ready output stream.
- Sits between the frequency-count stage and the tree-build stage.

Parameters:
- DSIZE, 18, entry width; the sorter compares the key field only.
- OFFSET, 8, payload width; key = data[DSIZE-1:OFFSET], symbol payload = data[OFFSET-1:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input entry valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  DSIZE  input entry.
- in_last  in  1  marks final entry of the frame.
- out_valid  out  1  sorted entry valid.
- out_ready  in  1  downstream accept.
- out_data  out  DSIZE  sorted entry.
- out_last  out  1  marks final sorted entry.
- out_cnt  out  4  number of entries in the current frame (1..8), stable from SORT until frame done.
- busy  out  1  high in SORT and DRAIN.
- err_key  out  1  sticky; set when an accepted entry has an all-ones key.
- err_clr  in  1  synchronous clear of err_key.

Behaviour:
- Reset (async, rst_n=0): state=LOAD, wr_idx=0, rd_idx=0, out_cnt=0, all lane regs and out buffer = all-ones, in_ready=1, out_valid=0, out_last=0, busy=0, err_key=0. Deassertion is synchronised by the top-level reset bridge.
- States: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - On in_valid&in_ready, lane[wr_idx]<=in_data and wr_idx++.
  - The frame closes on the beat with in_last=1 or on the 8th beat, whichever comes first. An 8th beat without in_last closes the frame; no error is raised.
  - On close: out_cnt<=wr_idx+1, next=SORT.
  - Lanes not written keep their all-ones pad, which is restored at each frame end.
- SORT (exactly 1 cycle):
  - Lane regs drive sorter inputs a0..a7.
  - Sorter outputs sort0 (smallest)..sort7 are captured into obuf[0..7].
  - rd_idx<=0, next=DRAIN.
- DRAIN:
  - out_valid=1, out_data=obuf[rd_idx], out_last=(rd_idx==out_cnt-1).
  - On out_valid&out_ready: rd_idx++.
  - On the last handshake: lanes<=all-ones, wr_idx<=0, next=LOAD.
  - out_data/out_last hold stable while out_valid&!out_ready.
- Latency: closing beat in cycle N, SORT in N+1, first out_valid in N+2.
  - Throughput per frame = k input beats + 1 + k output beats, where k = entry count.
  - No overlap between frames; in_ready=0 outside LOAD.
- Keys:
  - The all-ones key is reserved as pad.
  - An accepted entry with that key sets err_key; output ordering for that frame is undefined.
  - err_clr and a set event in the same cycle: set wins.
- Equal keys: relative order of entries with equal keys is unspecified. Output is a permutation of the inputs, non-decreasing in key.
- in_valid outside LOAD is ignored (no acceptance). in_last on a non-handshake cycle is ignored.
- Reset mid-frame: the frame is discarded, with all outputs returning to reset values immediately.

Decomposition:
- Shared package sortnet_pkg holds:
  - SORT_LANES=8.
  - KEY_W=DSIZE-OFFSET.
  - PAD_ENTRY = all-ones of DSIZE.
  - State encoding enum {LOAD, SORT, DRAIN}.
- One sub-module: the existing BitonicSortX8 instance, with DSIZE and OFFSET passed through.
- Lane registers, output buffer, FSM and counters are local to this block; no further hierarchy.

Test Plan:
- 8 entries with keys 7,3,5,1,6,0,4,2 (payload = lane index), out_ready=1 -> out keys 0..7; out_last on key 7; out_cnt=8; first out_valid 2 cycles after 8th beat.
- 3 entries with keys 9,2,5, in_last on 3rd -> exactly 3 outputs 2,5,9; out_last on 9; no pad entry emitted.
- 1 entry, key 4, in_last -> single output with out_valid and out_last together; then in_ready=1 the cycle after the handshake.
- DRAIN with out_ready toggled 1010... -> out_data stable during stalls; sequence unchanged; in_valid held high during DRAIN is not accepted.
- Entry with key all-ones -> err_key=1 and stays set; err_clr pulse -> 0; err_clr coincident with a new all-ones entry -> remains 1.
- rst_n pulled low in DRAIN after 2 of 5 outputs -> out_valid=0 asynchronously; after release in_ready=1; the next 2-entry frame sorts correctly with no stale data.

Source files
------------

// File: rtl/sortnet_pkg.sv
// Shared definitions for the Huffman sortnet: lane count, default entry geometry,
// pad entry and the frame sequencer state encoding.
package sortnet_pkg;

    localparam int SORT_LANES = 8;
    localparam int DSIZE_DEF  = 18;
    localparam int OFFSET_DEF = 8;
    localparam int KEY_W      = DSIZE_DEF - OFFSET_DEF;

    localparam logic [DSIZE_DEF-1:0] PAD_ENTRY = '1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/BitonicSortX8.sv
// Combinational 8-input bitonic sort network, ascending by key field only.
// Payload bits travel with their key but never influence the order.
module BitonicSortX8 #(
    parameter int DSIZE  = 18,
    parameter int OFFSET = 8
) (
    input  logic [DSIZE-1:0] a0,
    input  logic [DSIZE-1:0] a1,
    input  logic [DSIZE-1:0] a2,
    input  logic [DSIZE-1:0] a3,
    input  logic [DSIZE-1:0] a4,
    input  logic [DSIZE-1:0] a5,
    input  logic [DSIZE-1:0] a6,
    input  logic [DSIZE-1:0] a7,
    output logic [DSIZE-1:0] sort0,
    output logic [DSIZE-1:0] sort1,
    output logic [DSIZE-1:0] sort2,
    output logic [DSIZE-1:0] sort3,
    output logic [DSIZE-1:0] sort4,
    output logic [DSIZE-1:0] sort5,
    output logic [DSIZE-1:0] sort6,
    output logic [DSIZE-1:0] sort7
);

    logic [DSIZE-1:0] v [8];
    logic [DSIZE-1:0] tmp;
    logic [2:0]       lo;
    logic [2:0]       hi;

    // Classic bitonic schedule: k = merge size, j = compare distance.
    always_comb begin
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        tmp  = '0;
        lo   = '0;
        hi   = '0;
        for (int k = 2; k <= 8; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                for (int i = 0; i < 8; i++) begin
                    lo = i[2:0];
                    hi = lo ^ j[2:0];
                    if (hi > lo) begin
                        if (((i & k) == 0) ?
                                (v[lo][DSIZE-1:OFFSET] > v[hi][DSIZE-1:OFFSET]) :
                                (v[lo][DSIZE-1:OFFSET] < v[hi][DSIZE-1:OFFSET])) begin
                            tmp   = v[lo];
                            v[lo] = v[hi];
                            v[hi] = tmp;
                        end
                    end
                end
            end
        end
    end

    assign sort0 = v[0];
    assign sort1 = v[1];
    assign sort2 = v[2];
    assign sort3 = v[3];
    assign sort4 = v[4];
    assign sort5 = v[5];
    assign sort6 = v[6];
    assign sort7 = v[7];

endmodule

// File: rtl/sort8_frame_sched.sv
// Frame sequencer around BitonicSortX8: loads 1..8 entries, sorts once in a single
// cycle, then drains exactly the received entries in ascending key order.
module sort8_frame_sched
    import sortnet_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int OFFSET = OFFSET_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_last,
    output logic [3:0]       out_cnt,
    output logic             busy,
    output logic             err_key,
    input  logic             err_clr
);

    localparam logic [DSIZE-1:0] PAD = '1;

    sched_state_t     state;
    logic [DSIZE-1:0] lane   [SORT_LANES];
    logic [DSIZE-1:0] obuf   [SORT_LANES];
    logic [DSIZE-1:0] sorted [SORT_LANES];
    logic [2:0]       wr_idx;
    logic [2:0]       rd_idx;
    logic             accept;
    logic             drain_done;

    BitonicSortX8 #(
        .DSIZE  (DSIZE),
        .OFFSET (OFFSET)
    ) u_sort (
        .a0    (lane[0]),   .a1    (lane[1]),   .a2    (lane[2]),   .a3    (lane[3]),
        .a4    (lane[4]),   .a5    (lane[5]),   .a6    (lane[6]),   .a7    (lane[7]),
        .sort0 (sorted[0]), .sort1 (sorted[1]), .sort2 (sorted[2]), .sort3 (sorted[3]),
        .sort4 (sorted[4]), .sort5 (sorted[5]), .sort6 (sorted[6]), .sort7 (sorted[7])
    );

    // Handshake outputs decode straight from the state register so an async
    // reset drops them in the same instant.
    assign in_ready   = (state == LOAD);
    assign busy       = (state != LOAD);
    assign out_valid  = (state == DRAIN);
    assign out_data   = obuf[rd_idx];
    assign out_last   = (state == DRAIN) && ({1'b0, rd_idx} == out_cnt - 4'd1);
    assign accept     = in_valid && (state == LOAD);
    assign drain_done = out_last && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            wr_idx  <= '0;
            rd_idx  <= '0;
            out_cnt <= '0;
            err_key <= 1'b0;
            for (int i = 0; i < SORT_LANES; i++) begin
                lane[i] <= PAD;
                obuf[i] <= PAD;
            end
        end else begin
            // A new reserved key beats a simultaneous clear.
            if (accept && (&in_data[DSIZE-1:OFFSET]))
                err_key <= 1'b1;
            else if (err_clr)
                err_key <= 1'b0;

            case (state)
                LOAD: begin
                    if (accept) begin
                        lane[wr_idx] <= in_data;
                        wr_idx       <= wr_idx + 3'd1;
                        if (in_last || (wr_idx == 3'd7)) begin
                            out_cnt <= {1'b0, wr_idx} + 4'd1;
                            state   <= SORT;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < SORT_LANES; i++)
                        obuf[i] <= sorted[i];
                    rd_idx <= '0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd_idx <= rd_idx + 3'd1;
                        // Restore pads so a short next frame never sees stale lanes.
                        if (drain_done) begin
                            for (int i = 0; i < SORT_LANES; i++)
                                lane[i] <= PAD;
                            wr_idx <= '0;
                            state  <= LOAD;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sort8_frame_sched.sv
// Directed bench for sort8_frame_sched: hand-computed sorted frames, stalls,
// reserved-key error flag and reset in the middle of a drain.
module tb_sort8_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        out_last;
    logic [3:0]  out_cnt;
    logic        busy;
    logic        err_key;
    logic        err_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [17:0] exp_tab [8];

    always #5 clk = ~clk;

    sort8_frame_sched #(.DSIZE(18), .OFFSET(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_cnt   (out_cnt),
        .busy      (busy),
        .err_key   (err_key),
        .err_clr   (err_clr)
    );

    function automatic logic [17:0] mk(input logic [9:0] key, input logic [7:0] pay);
        return {key, pay};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1 after the beat's edge.
    task automatic push(input logic [9:0] key, input logic [7:0] pay, input logic last);
        in_valid = 1'b1;
        in_data  = mk(key, pay);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drains n entries against exp_tab; with stall, each beat waits one
    // cycle with out_ready low while in_valid is held high.
    task automatic drain(input int n, input bit stall, input string tag);
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                in_valid  = 1'b1;
                in_data   = mk(10'd1, 8'hEE);
                out_ready = 1'b0;
                check_eq({tag, "_stall_valid"}, out_valid, 1'b1);
                check_eq({tag, "_stall_rdy"}, in_ready, 1'b0);
                @(posedge clk); #1;
                check_eq({tag, "_stall_data"}, out_data, exp_tab[i]);
            end
            check_eq({tag, "_valid"}, out_valid, 1'b1);
            check_eq({tag, "_data"}, out_data, exp_tab[i]);
            check_eq({tag, "_last"}, out_last, (i == n - 1));
            if (i == n - 1) in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check_eq({tag, "_done_valid"}, out_valid, 1'b0);
        check_eq({tag, "_done_rdy"}, in_ready, 1'b1);
    endtask

    // Called right after the closing beat: checks the SORT cycle, steps into DRAIN.
    task automatic sort_cycle(input logic [3:0] cnt, input string tag);
        check_eq({tag, "_sort_busy"}, busy, 1'b1);
        check_eq({tag, "_sort_valid"}, out_valid, 1'b0);
        check_eq({tag, "_sort_rdy"}, in_ready, 1'b0);
        check_eq({tag, "_cnt"}, out_cnt, cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err_key, 1'b0);
        check_eq("rst_cnt", out_cnt, 4'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full frame closed by the 8th beat, no in_last.
        push(10'd7, 8'd0, 1'b0); push(10'd3, 8'd1, 1'b0);
        push(10'd5, 8'd2, 1'b0); push(10'd1, 8'd3, 1'b0);
        push(10'd6, 8'd4, 1'b0); push(10'd0, 8'd5, 1'b0);
        push(10'd4, 8'd6, 1'b0); push(10'd2, 8'd7, 1'b0);
        exp_tab[0] = mk(10'd0, 8'd5); exp_tab[1] = mk(10'd1, 8'd3);
        exp_tab[2] = mk(10'd2, 8'd7); exp_tab[3] = mk(10'd3, 8'd1);
        exp_tab[4] = mk(10'd4, 8'd6); exp_tab[5] = mk(10'd5, 8'd2);
        exp_tab[6] = mk(10'd6, 8'd4); exp_tab[7] = mk(10'd7, 8'd0);
        sort_cycle(4'd8, "f8");
        drain(8, 1'b0, "f8");

        // Short frame: pads must never appear.
        push(10'd9, 8'h10, 1'b0); push(10'd2, 8'h11, 1'b0); push(10'd5, 8'h12, 1'b1);
        exp_tab[0] = mk(10'd2, 8'h11); exp_tab[1] = mk(10'd5, 8'h12);
        exp_tab[2] = mk(10'd9, 8'h10);
        sort_cycle(4'd3, "f3");
        drain(3, 1'b0, "f3");

        // Single-entry frame.
        push(10'd4, 8'hAA, 1'b1);
        exp_tab[0] = mk(10'd4, 8'hAA);
        sort_cycle(4'd1, "f1");
        drain(1, 1'b0, "f1");

        // Stalled drain with in_valid held high.
        push(10'd100, 8'd1, 1'b0); push(10'd50, 8'd2, 1'b0);
        push(10'd75, 8'd3, 1'b0);  push(10'd25, 8'd4, 1'b1);
        exp_tab[0] = mk(10'd25, 8'd4); exp_tab[1] = mk(10'd50, 8'd2);
        exp_tab[2] = mk(10'd75, 8'd3); exp_tab[3] = mk(10'd100, 8'd1);
        sort_cycle(4'd4, "fst");
        drain(4, 1'b1, "fst");
        // The held in_valid must not have leaked an entry into the next frame.
        push(10'd12, 8'h5A, 1'b1);
        exp_tab[0] = mk(10'd12, 8'h5A);
        sort_cycle(4'd1, "fpost");
        drain(1, 1'b0, "fpost");

        // Reserved all-ones key sets the sticky error.
        check_eq("err_before", err_key, 1'b0);
        push(10'h3FF, 8'h01, 1'b1);
        check_eq("err_set", err_key, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        check_eq("err_sticky", err_key, 1'b1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        check_eq("err_cleared", err_key, 1'b0);
        err_clr = 1'b1;
        push(10'h3FF, 8'h02, 1'b1);
        err_clr = 1'b0;
        check_eq("err_set_wins", err_key, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

        // Reset after 2 of 5 outputs.
        push(10'd5, 8'd0, 1'b0); push(10'd4, 8'd0, 1'b0); push(10'd3, 8'd0, 1'b0);
        push(10'd2, 8'd0, 1'b0); push(10'd1, 8'd0, 1'b1);
        exp_tab[0] = mk(10'd1, 8'd0); exp_tab[1] = mk(10'd2, 8'd0);
        sort_cycle(4'd5, "frst");
        for (int i = 0; i < 2; i++) begin
            check_eq("frst_data", out_data, exp_tab[i]);
            out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        end
        check_eq("frst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("frst_async_valid", out_valid, 1'b0);
        check_eq("frst_async_busy", busy, 1'b0);
        check_eq("frst_async_cnt", out_cnt, 4'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("frst_rdy", in_ready, 1'b1);
        push(10'd8, 8'h21, 1'b0); push(10'd6, 8'h22, 1'b1);
        exp_tab[0] = mk(10'd6, 8'h22); exp_tab[1] = mk(10'd8, 8'h21);
        sort_cycle(4'd2, "fafter");
        drain(2, 1'b0, "fafter");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
